// File: rtl/serial_in_if.sv
// Bus between a serial_in receiver and its controller: rate tick, control strobes,
// the serial line and the recovered word with its status.
interface serial_in_if #(
   parameter int unsigned DATA_BIT = 16
);
   logic                i_tick;
   logic                i_start;
   logic                i_stop;
   logic                i_repeat;
   logic                i_serial;
   logic [DATA_BIT-1:0] o_data;
   logic                o_busy;
   logic                o_done_tick;

   modport master (
      output i_tick, i_start, i_stop, i_repeat, i_serial,
      input  o_data, o_busy, o_done_tick
   );

   modport slave (
      input  i_tick, i_start, i_stop, i_repeat, i_serial,
      output o_data, o_busy, o_done_tick
   );
endinterface

// File: rtl/serial_in.sv
// LSB-first serial word receiver: synchronises the line, samples each bit once at a
// fixed tick offset and presents the finished word with a one-clock done pulse.
module serial_in #(
   parameter int unsigned DATA_BIT     = 16,
   parameter int unsigned TICK_PER_BIT = 16,
   parameter int unsigned SAMPLE_TICK  = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   serial_in_if.slave bus
);
   localparam int unsigned CNT_W = 8;
   localparam int unsigned BIT_W = 6;
   localparam logic [CNT_W-1:0] SAMPLE_AT = CNT_W'(SAMPLE_TICK);
   localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(TICK_PER_BIT - 1);
   localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BIT - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RECV = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t              state;
   logic [1:0]          sync_reg;
   logic [CNT_W-1:0]    count_reg;
   logic [BIT_W-1:0]    bit_reg;
   logic [DATA_BIT-1:0] buf_reg;
   logic [DATA_BIT-1:0] data_reg;
   logic                busy_reg;
   logic                done_reg;
   logic                line_sync;

   assign line_sync       = sync_reg[1];
   assign bus.o_data      = data_reg;
   assign bus.o_busy      = busy_reg;
   assign bus.o_done_tick = done_reg;

   // New bit enters at the MSB so the first received bit ends up in bit 0.
   function automatic logic [DATA_BIT-1:0] shift_in(input logic [DATA_BIT-1:0] cur,
                                                    input logic b);
      return (cur >> 1) | (DATA_BIT'(b) << (DATA_BIT - 1));
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         sync_reg  <= 2'b00;
         count_reg <= '0;
         bit_reg   <= '0;
         buf_reg   <= '0;
         data_reg  <= '0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         sync_reg <= {sync_reg[0], bus.i_serial};
         done_reg <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.i_start) begin
                  state     <= S_RECV;
                  busy_reg  <= 1'b1;
                  count_reg <= '0;
                  bit_reg   <= '0;
                  buf_reg   <= '0;
               end
            end
            S_RECV: begin
               if (bus.i_stop) begin
                  state    <= S_IDLE;
                  busy_reg <= 1'b0;
               end else if (bus.i_tick) begin
                  if (count_reg == SAMPLE_AT)
                     buf_reg <= shift_in(buf_reg, line_sync);
                  if (count_reg == LAST_TICK) begin
                     count_reg <= '0;
                     if (bit_reg == LAST_BIT) begin
                        state    <= S_DONE;
                        busy_reg <= 1'b0;
                        done_reg <= 1'b1;
                        data_reg <= (count_reg == SAMPLE_AT) ?
                                    shift_in(buf_reg, line_sync) : buf_reg;
                     end else begin
                        bit_reg <= bit_reg + BIT_W'(1);
                     end
                  end else begin
                     count_reg <= count_reg + CNT_W'(1);
                  end
               end
            end
            S_DONE: begin
               // On repeat the done clock is already tick 0 of the next word's bit 0,
               // keeping back-to-back words exactly DATA_BIT*TICK_PER_BIT ticks apart.
               if (bus.i_repeat && !bus.i_stop) begin
                  state     <= S_RECV;
                  busy_reg  <= 1'b1;
                  bit_reg   <= '0;
                  count_reg <= bus.i_tick ? CNT_W'(1) : '0;
                  buf_reg   <= (bus.i_tick && SAMPLE_AT == '0) ?
                               shift_in('0, line_sync) : '0;
               end else begin
                  state    <= S_IDLE;
                  busy_reg <= 1'b0;
               end
            end
            default: begin
               state    <= S_IDLE;
               busy_reg <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_serial_in.sv
// Directed bench for serial_in: table of single-word receptions plus abort, repeat
// and mid-word reset sequences. Period p is the clock period after acceptance edge p-1.
module tb_serial_in;
   localparam int unsigned DW = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   serial_in_if #(.DATA_BIT(DW)) bus ();

   serial_in #(
      .DATA_BIT    (DW),
      .TICK_PER_BIT(16),
      .SAMPLE_TICK (8)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] word;
      int          div;
      int          skew;
      int          glitch_p;
      logic [15:0] exp_data;
      int          exp_done_p;
   } vec_t;

   vec_t tbl[7];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic tick, input logic start, input logic stop,
                        input logic rep, input logic ser);
      @(negedge clk);
      bus.i_tick   = tick;
      bus.i_start  = start;
      bus.i_stop   = stop;
      bus.i_repeat = rep;
      bus.i_serial = ser;
   endtask

   // Line level in period p: bits LSB-first, bit_len clocks each, first bit at period 1+skew.
   function automatic logic line_at(input logic [31:0] bits, input int nbits, input int p,
                                    input int bit_len, input int skew);
      int rel;
      int idx;
      rel = p - 1 - skew;
      if (rel < 0) return 1'b1;
      idx = rel / bit_len;
      if (idx >= nbits) return 1'b1;
      return bits[idx];
   endfunction

   task automatic run_vec(input vec_t v, input int id);
      int          done_cnt;
      int          done_p;
      int          busy_bad;
      logic [15:0] got;
      done_cnt = 0;
      done_p   = -1;
      busy_bad = 0;
      got      = '0;
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      for (int p = 1; p <= v.exp_done_p + 4; p++) begin
         logic ser;
         ser = line_at({16'h0, v.word}, 16, p, 16 * v.div, v.skew);
         if (p == v.glitch_p) ser = ~ser;
         drive(((p - 1) % v.div) == 0, 1'b0, 1'b0, 1'b0, ser);
         if (bus.o_done_tick) begin
            done_cnt++;
            done_p = p;
            got    = bus.o_data;
         end
         if (bus.o_busy !== (p < v.exp_done_p)) busy_bad++;
      end
      check($sformatf("vec%0d data", id), 64'(got), 64'(v.exp_data));
      check($sformatf("vec%0d done_count", id), 64'(done_cnt), 64'd1);
      check($sformatf("vec%0d done_period", id), 64'(done_p), 64'(v.exp_done_p));
      check($sformatf("vec%0d busy_bad_periods", id), 64'(busy_bad), 64'd0);
      check($sformatf("vec%0d data_hold", id), 64'(bus.o_data), 64'(v.exp_data));
   endtask

   initial begin
      int          done_cnt;
      int          busy_cnt;
      int          busy_bad;
      int          d1_p;
      int          d2_p;
      logic [15:0] d1;
      logic [15:0] d2;
      vec_t        v;

      tbl[0] = '{16'hA5C3, 1,  0,  0, 16'hA5C3,  257};
      tbl[1] = '{16'h0001, 4,  0,  0, 16'h0001, 1022};
      tbl[2] = '{16'hA5C3, 1,  3,  0, 16'hA5C3,  257};
      tbl[3] = '{16'hA5C3, 1, -3,  0, 16'hA5C3,  257};
      tbl[4] = '{16'h5A3C, 1,  0, 50, 16'h5A3C,  257};
      tbl[5] = '{16'h0000, 1,  0,  0, 16'h0000,  257};
      tbl[6] = '{16'h1234, 1,  0,  0, 16'h1234,  257};

      bus.i_tick   = 1'b0;
      bus.i_start  = 1'b0;
      bus.i_stop   = 1'b0;
      bus.i_repeat = 1'b0;
      bus.i_serial = 1'b1;
      repeat (3) @(negedge clk);
      check("reset data", 64'(bus.o_data), 64'd0);
      check("reset busy", 64'(bus.o_busy), 64'd0);
      check("reset done", 64'(bus.o_done_tick), 64'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 7; i++) run_vec(tbl[i], i);

      // Abort after five bits of 16'hFFFF; previous word 16'h1234 must survive.
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      for (int p = 1; p <= 81; p++)
         drive(1'b1, 1'b0, p == 81, 1'b0, line_at(32'h0000FFFF, 16, p, 16, 0));
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      check("abort busy_next", 64'(bus.o_busy), 64'd0);
      done_cnt = 0;
      for (int p = 83; p <= 400; p++) begin
         drive(1'b1, 1'b0, 1'b0, 1'b0, line_at(32'h0000FFFF, 16, p, 16, 0));
         if (bus.o_done_tick) done_cnt++;
      end
      check("abort no_done", 64'(done_cnt), 64'd0);
      check("abort data_kept", 64'(bus.o_data), 64'h1234);
      v = '{16'h00F0, 1, 0, 0, 16'h00F0, 257};
      run_vec(v, 10);

      // Back-to-back words with repeat: 16'h8001 then 16'h7FFE.
      done_cnt = 0;
      busy_bad = 0;
      d1_p = -1; d2_p = -1; d1 = '0; d2 = '0;
      drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      for (int p = 1; p <= 520; p++) begin
         drive(1'b1, 1'b0, 1'b0, p <= 300, line_at(32'h7FFE8001, 32, p, 16, 0));
         if (bus.o_done_tick) begin
            done_cnt++;
            if (done_cnt == 1) begin d1_p = p; d1 = bus.o_data; end
            else begin d2_p = p; d2 = bus.o_data; end
         end
         if (bus.o_busy !== ((p >= 1 && p < 257) || (p >= 258 && p < 513))) busy_bad++;
      end
      check("repeat done_count", 64'(done_cnt), 64'd2);
      check("repeat first_period", 64'(d1_p), 64'd257);
      check("repeat second_period", 64'(d2_p), 64'd513);
      check("repeat first_data", 64'(d1), 64'h8001);
      check("repeat second_data", 64'(d2), 64'h7FFE);
      check("repeat busy_bad_periods", 64'(busy_bad), 64'd0);

      // Reset during bit 9, then line activity without a start.
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      for (int p = 1; p <= 149; p++)
         drive(1'b1, 1'b0, 1'b0, 1'b0, line_at(32'h0000BEEF, 16, p, 16, 0));
      rst_n = 1'b0;
      #1;
      check("midreset data", 64'(bus.o_data), 64'd0);
      check("midreset busy", 64'(bus.o_busy), 64'd0);
      check("midreset done", 64'(bus.o_done_tick), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      done_cnt = 0;
      busy_cnt = 0;
      for (int p = 0; p < 300; p++) begin
         drive(1'b1, 1'b0, 1'b0, 1'b0, p[2]);
         if (bus.o_done_tick) done_cnt++;
         if (bus.o_busy) busy_cnt++;
      end
      check("postreset no_done", 64'(done_cnt), 64'd0);
      check("postreset no_busy", 64'(busy_cnt), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
